// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - E-stage multiply/divide unit owning the HI/LO registers
// Fixed-latency mult/div with single-cycle mthi/mtlo; the result is computed at issue and committed after the busy window.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy_E,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mult, is_div;
  logic [63:0] smul, umul, result;
  logic [31:0] a_abs, b_abs, b_abs_safe, b_safe;
  logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;

  assign is_mult = (md_op == 3'd1) || (md_op == 3'd2);
  assign is_div  = (md_op == 3'd3) || (md_op == 3'd4);
  assign start   = (is_mult || is_div) && (state_q == IDLE);
  assign busy_E  = (state_q == RUN);
  assign HI      = hi_q;
  assign LO      = lo_q;

  assign smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign umul = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes: quotient sign is the XOR, remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  assign a_abs      = A[31] ? (~A + 32'd1) : A;
  assign b_abs      = B[31] ? (~B + 32'd1) : B;
  assign b_abs_safe = (B == 32'd0) ? 32'd1 : b_abs;
  assign b_safe     = (B == 32'd0) ? 32'd1 : B;
  assign sq_mag     = a_abs / b_abs_safe;
  assign sr_mag     = a_abs % b_abs_safe;
  assign sq         = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr         = A[31] ? (~sr_mag + 32'd1) : sr_mag;
  assign uq         = A / b_safe;
  assign ur         = A % b_safe;

  always_comb begin
    result = 64'd0;
    case (md_op)
      3'd1:    result = smul;
      3'd2:    result = umul;
      3'd3:    result = {sr, sq};
      3'd4:    result = {ur, uq};
      default: result = 64'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pend_d    = result;
          pend_wr_d = !(is_div && (B == 32'd0));
          cnt_d     = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          state_d   = RUN;
        end else if (md_op == 3'd5) begin
          hi_d = A;
        end else if (md_op == 3'd6) begin
          lo_d = A;
        end
      end
      RUN: begin
        // Any md_op arriving here is a hazard-unit violation and is ignored.
        if (cnt_q == 4'd1) begin
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_q    <= 64'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
// Directed steps; expected HI/LO/latency go into a scoreboard queue at issue and are popped at completion.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy_E;
  logic [31:0] HI;
  logic [31:0] LO;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .start  (start),
    .busy_E (busy_E),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is just after a negedge; returns just after the negedge where busy_E has dropped.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int n,
                        input bit disturb);
    exp_t e;
    int   cyc;
    bit   done;
    e.hi = eh; e.lo = el; e.cyc = n;
    sb.push_back(e);
    md_op = op; A = a; B = b;
    #1;
    chk("start_on_issue", start, 1);
    @(negedge clk);
    md_op = 3'd0; A = $urandom; B = $urandom;
    cyc = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy_E) begin
        cyc++;
        md_op = 3'd0;
        chk("hi_held_busy", HI, m_hi);
        chk("lo_held_busy", LO, m_lo);
        if (disturb && cyc >= 2 && cyc <= 4) begin
          md_op = (cyc == 4) ? 3'd5 : 3'd1;
          A = $urandom; B = $urandom;
          #1;
          chk("start_blocked_busy", start, 0);
        end
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    md_op = 3'd0;
    chk("completion_timeout", done, 1);
    e = sb.pop_front();
    chk("busy_cycles", cyc, e.cyc);
    chk("hi_result", HI, e.hi);
    chk("lo_result", LO, e.lo);
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    md_op = op; A = a;
    #1;
    chk("start_mt", start, 0);
    @(negedge clk);
    md_op = 3'd0;
    if (op == 3'd5) m_hi = a; else m_lo = a;
    chk("busy_mt", busy_E, 0);
    chk("hi_mt", HI, m_hi);
    chk("lo_mt", LO, m_lo);
  endtask

  initial begin
    reset = 1'b1; md_op = 3'd0; A = 32'd0; B = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_hi", HI, 0);
    chk("reset_lo", LO, 0);
    chk("reset_busy", busy_E, 0);
    chk("reset_start", start, 0);

    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 0);
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 0);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
    run_op(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1);

    mt(3'd5, 32'h12345678);
    run_op(3'd4, 32'h00000055, 32'd0, 32'h12345678, 32'd3, 10, 0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 0);
    mt(3'd6, 32'hDEADBEEF);

    md_op = 3'd7; A = 32'hA5A5A5A5; B = 32'd3;
    #1;
    chk("start_op7", start, 0);
    @(negedge clk);
    md_op = 3'd0;
    chk("busy_op7", busy_E, 0);
    chk("hi_op7", HI, m_hi);
    chk("lo_op7", LO, m_lo);

    md_op = 3'd1; A = 32'd3; B = 32'd4;
    #1;
    chk("start_abort_mult", start, 1);
    @(negedge clk);
    md_op = 3'd0;
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("busy_async_reset", busy_E, 0);
    chk("hi_async_reset", HI, 0);
    chk("lo_async_reset", LO, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_after_abort", busy_E, 0);
    chk("hi_after_abort", HI, 0);
    chk("lo_after_abort", LO, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
